// File: rtl/muldiv_pkg.sv
// Shared op, state and extended-opcode definitions for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam int OP_BITS = 2;

  typedef enum logic [OP_BITS-1:0] {
    MD_MUL  = 2'd0,
    MD_MULH = 2'd1,
    MD_DIV  = 2'd2,
    MD_REM  = 2'd3
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

  // Extended-opcode function field values that execute decodes onto the ops above.
  localparam logic [5:0] XOP_MUL  = 6'h18;
  localparam logic [5:0] XOP_MULH = 6'h19;
  localparam logic [5:0] XOP_DIV  = 6'h1a;
  localparam logic [5:0] XOP_REM  = 6'h1b;

  function automatic md_op_e xop_to_op(input logic [5:0] xop);
    md_op_e op;
    case (xop)
      XOP_MULH: op = MD_MULH;
      XOP_DIV:  op = MD_DIV;
      XOP_REM:  op = MD_REM;
      default:  op = MD_MUL;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Issue/result bundle between the execute stage (master) and the multiply/divide unit (slave).
interface muldiv_if
  import muldiv_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int RD_BITS = 4
);

  logic               start;
  logic [OP_BITS-1:0] op;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [RD_BITS-1:0] rd;
  logic               flush;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   result;
  logic [RD_BITS-1:0] done_rd;

  modport master (
    output start, op, a, b, rd, flush,
    input  busy, done, result, done_rd
  );

  modport slave (
    input  start, op, a, b, rd, flush,
    output busy, done, result, done_rd
  );

endinterface

// File: rtl/muldiv_datapath.sv
// Magnitude-domain shift-add multiplier and restoring divider with a final sign-fix stage.
module muldiv_datapath
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             load,
  input  logic             step,
  input  logic             fix,
  input  md_op_e           op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result
);

  md_op_e             op_q;
  logic               sign_a_q;
  logic               sign_b_q;
  logic               div_zero_q;
  logic [WIDTH-1:0]   abs_a_q;
  logic [WIDTH-1:0]   abs_b_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [WIDTH:0]     rem_q;
  logic [WIDTH-1:0]   quo_q;
  logic [WIDTH-1:0]   result_q;

  logic [WIDTH:0]     prod_sum;
  logic [2*WIDTH-1:0] prod_next;
  logic [WIDTH+1:0]   rem_shift;
  logic [WIDTH+1:0]   rem_trial;
  logic [WIDTH:0]     rem_next;
  logic [WIDTH-1:0]   quo_next;
  logic [2*WIDTH-1:0] prod_signed;
  logic [WIDTH-1:0]   quo_signed;
  logic [WIDTH-1:0]   rem_signed;
  logic [WIDTH-1:0]   a_signed;
  logic [WIDTH-1:0]   fix_value;

  // INT_MIN maps onto 2^(WIDTH-1), which is still exact as an unsigned magnitude.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  // Both engines step together; only the one selected by op_q is read at fix time.
  always_comb begin
    prod_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, abs_a_q} : '0);
    prod_next = {prod_sum, prod_q[WIDTH-1:1]};
    rem_shift = {rem_q, quo_q[WIDTH-1]};
    rem_trial = rem_shift - {2'b00, abs_b_q};
    if (rem_trial[WIDTH+1]) begin
      rem_next = rem_shift[WIDTH:0];
      quo_next = {quo_q[WIDTH-2:0], 1'b0};
    end else begin
      rem_next = rem_trial[WIDTH:0];
      quo_next = {quo_q[WIDTH-2:0], 1'b1};
    end
  end

  always_comb begin
    prod_signed = (sign_a_q ^ sign_b_q) ? -prod_q : prod_q;
    quo_signed  = (sign_a_q ^ sign_b_q) ? -quo_q : quo_q;
    rem_signed  = sign_a_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
    a_signed    = sign_a_q ? -abs_a_q : abs_a_q;
    fix_value   = '0;
    case (op_q)
      MD_MUL:  fix_value = prod_signed[WIDTH-1:0];
      MD_MULH: fix_value = prod_signed[2*WIDTH-1:WIDTH];
      MD_DIV:  fix_value = div_zero_q ? '1 : quo_signed;
      MD_REM:  fix_value = div_zero_q ? a_signed : rem_signed;
      default: fix_value = '0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      op_q       <= MD_MUL;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      div_zero_q <= 1'b0;
      abs_a_q    <= '0;
      abs_b_q    <= '0;
      prod_q     <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      result_q   <= '0;
    end else if (load) begin
      op_q       <= op;
      sign_a_q   <= a[WIDTH-1];
      sign_b_q   <= b[WIDTH-1];
      div_zero_q <= (b == '0);
      abs_a_q    <= magnitude(a);
      abs_b_q    <= magnitude(b);
      prod_q     <= {{WIDTH{1'b0}}, magnitude(b)};
      rem_q      <= '0;
      quo_q      <= magnitude(a);
    end else if (step) begin
      prod_q     <= prod_next;
      rem_q      <= rem_next;
      quo_q      <= quo_next;
    end else if (fix) begin
      result_q   <= fix_value;
    end
  end

  assign result = result_q;

endmodule

// File: rtl/muldiv_sequencer.sv
// Fixed-latency MUL/MULH/DIV/REM unit: IDLE -> RUN (WIDTH steps) -> FIX -> DONE, abortable by flush.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int RD_BITS = 4
) (
  input logic      i_clk,
  input logic      i_reset,
  muldiv_if.slave  bus
);

  localparam int CNT_BITS = $clog2(WIDTH + 1);
  localparam logic [CNT_BITS-1:0] LAST_STEP = CNT_BITS'(WIDTH - 1);

  md_state_e          state_q;
  md_state_e          state_d;
  logic [CNT_BITS-1:0] count_q;
  logic [RD_BITS-1:0] rd_q;
  logic               load;
  logic               step;
  logic               fix;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   dp_result;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        count_q <= '0;
        rd_q    <= bus.rd;
      end else if (step) begin
        count_q <= count_q + CNT_BITS'(1);
      end
    end
  end

  // Flush wins over start in IDLE and aborts RUN/FIX, but a DONE pulse is never retracted.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    fix     = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.flush) begin
          load    = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (bus.flush) begin
          state_d = ST_IDLE;
        end else begin
          step = 1'b1;
          if (count_q == LAST_STEP) begin
            state_d = ST_FIX;
          end
        end
      end
      ST_FIX: begin
        busy = 1'b1;
        if (bus.flush) begin
          state_d = ST_IDLE;
        end else begin
          fix     = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  muldiv_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .load    (load),
    .step    (step),
    .fix     (fix),
    .op      (md_op_e'(bus.op)),
    .a       (bus.a),
    .b       (bus.b),
    .result  (dp_result)
  );

  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.result  = done ? dp_result : '0;
  assign bus.done_rd = done ? rd_q : '0;

endmodule
